// File: rtl/regfile_write_arbiter_if.sv
// Bus shared by the register-bank write arbiter and the blocks around it.
//
// Requester side (driven by the write-back sources):
//   req   [NREQ]      per-requester valid, held until accepted
//   addr  [NREQ*AW]   requester i address in bits [i*AW +: AW]
//   data  [NREQ*DW]   requester i data in bits [i*DW +: DW]
//   lock  [NREQ]      per-requester lock request (only with ARB_LOCK_EN)
//   gnt   [NREQ]      one-hot ready back to the requesters
//
// Register-bank side (driven by the arbiter):
//   wr_en, wr_addr, wr_data, row_en [2**AW], wr_src [clog2(NREQ)]
//
// Handshake: requester i transfers on the rising clk edge where
// req[i] & gnt[i] is 1. req must stay high (with stable addr/data) until
// that edge. gnt is combinational from req/lock and the arbiter's own state.
//
// Optional feature macro: ARB_LOCK_EN adds the lock signal.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
);
  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NREG-1:0]    row_en;
  logic [SW-1:0]      wr_src;

  // Requester / testbench side.
  modport master (
    output req, addr, data,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt, wr_en, wr_addr, wr_data, row_en, wr_src
  );

  // Arbiter side.
  modport slave (
    input  req, addr, data,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt, wr_en, wr_addr, wr_data, row_en, wr_src
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// The winning request is turned into a registered write (strobe, address,
// data, source index) plus a one-hot row enable that feeds the DFF enable
// pins of each register row directly.
//
// Ports:
//   clk        clock, rising edge active
//   rst        asynchronous, active-low reset
//   bus        regfile_write_arbiter_if.slave (req/addr/data/[lock]/gnt and
//              the registered wr_en/wr_addr/wr_data/row_en/wr_src)
//   state_dbg  current FSM state (0 = IDLE, 1 = LOCKED)
//   ptr_dbg    current round-robin pointer (highest-priority requester)
//
// Optional feature macro: ARB_LOCK_EN. When defined, a requester that wins
// with lock asserted keeps the port for up to MAX_LOCK consecutive grants.
// Without it the FSM never leaves IDLE and arbitration is pure round-robin.
module regfile_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4,
  localparam int SW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_write_arbiter_if.slave bus,
  output logic          state_dbg,
  output logic [SW-1:0] ptr_dbg
);

  localparam int NREG = 1 << AW;

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("regfile_write_arbiter: NREQ must be in 2..8");
  end
  if (MAX_LOCK < 1) begin : g_bad_max_lock
    $error("regfile_write_arbiter: MAX_LOCK must be at least 1");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;

  // Search start for the round-robin scan, and its result.
  logic [SW-1:0] base;
  logic          rr_found;
  logic [SW-1:0] rr_win;

  // Final winner of this cycle (round-robin or the lock owner).
  logic          win_valid;
  logic [SW-1:0] win;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  // (p + k) mod NREQ; NREQ is a constant so this folds to small logic.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return SW'(s);
  endfunction

  // First requesting index in the order base, base+1, ..., base-1.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && bus.req[wrap_add(base, k)]) begin
        rr_found = 1'b1;
        rr_win   = wrap_add(base, k);
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [SW-1:0] owner;
  logic [SW-1:0] owner_next;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_next;
  logic          arbitrate;

  // While locked, ptr sits at the owner. If the lock is dropped this cycle
  // the scan must start just past the owner so others can win immediately.
  always_comb begin
    base = ptr;
    if (state == LOCKED) begin
      base = wrap_add(owner, 1);
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    owner_next    = owner;
    lock_cnt_next = lock_cnt;
    win_valid     = 1'b0;
    win           = '0;
    arbitrate     = 1'b0;

    case (state)
      IDLE: begin
        arbitrate = 1'b1;
      end
      LOCKED: begin
        if (bus.req[owner] && bus.lock[owner]) begin
          win_valid = 1'b1;
          win       = owner;
          if (lock_cnt == CW'(MAX_LOCK - 1)) begin
            // This grant reaches the limit: it completes, then release.
            state_next    = IDLE;
            ptr_next      = wrap_add(owner, 1);
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt + 1'b1;
          end
        end else begin
          // Owner withdrew req or lock: release and arbitrate this cycle.
          state_next    = IDLE;
          ptr_next      = wrap_add(owner, 1);
          lock_cnt_next = '0;
          arbitrate     = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (arbitrate && rr_found) begin
      win_valid = 1'b1;
      win       = rr_win;
      ptr_next  = wrap_add(rr_win, 1);
      // A single-grant lock limit means locking never holds anything.
      if (bus.lock[rr_win] && (MAX_LOCK > 1)) begin
        state_next    = LOCKED;
        owner_next    = rr_win;
        ptr_next      = rr_win;
        lock_cnt_next = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      owner    <= owner_next;
      lock_cnt <= lock_cnt_next;
    end
  end
`else
  assign base = ptr;

  always_comb begin
    state_next = IDLE;
    ptr_next   = ptr;
    win_valid  = rr_found;
    win        = rr_win;
    if (rr_found) begin
      ptr_next = wrap_add(rr_win, 1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  assign win_addr = bus.addr[int'(win)*AW +: AW];
  assign win_data = bus.data[int'(win)*DW +: DW];

  // gnt depends only on req/lock and internal state, never on wr_*.
  always_comb begin
    bus.gnt = '0;
    if (rst && win_valid) begin
      bus.gnt[win] = 1'b1;
    end
  end

  // Registered write port. Address/data/source hold when nothing is granted;
  // only the strobe and row enable drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.row_en  <= '0;
      bus.wr_src  <= '0;
    end else if (win_valid) begin
      bus.wr_en   <= 1'b1;
      bus.wr_addr <= win_addr;
      bus.wr_data <= win_data;
      bus.row_en  <= NREG'(1) << win_addr;
      bus.wr_src  <= win;
    end else begin
      bus.wr_en   <= 1'b0;
      bus.row_en  <= '0;
    end
  end

  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule
